// File: rtl/sprite_rom_arbiter_if.sv
// Bundle between the sprite engines / sprite ROM and the sprite ROM arbiter.
// Requester operands are packed per requester: slot i sits at [i*W +: W].
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int PIX_W   = 5
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                             frame_start;
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_base;
  logic [NUM_REQ-1:0][4:0]          req_x;
  logic [NUM_REQ-1:0][5:0]          req_y;
  logic [NUM_REQ-1:0]               gnt;
  logic                             rom_rd;
  logic [ADDR_W-1:0]                rom_addr;
  logic [PIX_W-1:0]                 rom_data;
  logic                             rsp_valid;
  logic [ID_W-1:0]                  rsp_id;
  logic [PIX_W-1:0]                 rsp_pixel;

  modport master (
    output frame_start, req, req_base, req_x, req_y, rom_data,
    input  gnt, rom_rd, rom_addr, rsp_valid, rsp_id, rsp_pixel
  );

  modport slave (
    input  frame_start, req, req_base, req_x, req_y, rom_data,
    output gnt, rom_rd, rom_addr, rsp_valid, rsp_id, rsp_pixel
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one sprite-ROM read port; returns the pixel tagged with
// the requester id ROM_LAT+2 cycles after the grant.

// Per-requester address generation and bounds check.
module sprite_rom_arbiter_lane #(
  parameter int ADDR_W = 16,
  parameter int SPR_W  = 24,
  parameter int SPR_H  = 45
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [4:0]        x,
  input  logic [5:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);
  logic [ADDR_W-1:0] rowOff;

  generate
    if (SPR_W == 24) begin : gShiftAdd
      assign rowOff = (ADDR_W'(y) << 4) + (ADDR_W'(y) << 3);
    end else begin : gMul
      assign rowOff = ADDR_W'(y) * ADDR_W'(SPR_W);
    end
  endgenerate

  // Sum wraps naturally in ADDR_W bits.
  assign addr = base + rowOff + ADDR_W'(x);
  assign oob  = (int'(x) >= SPR_W) || (int'(y) >= SPR_H);
endmodule

module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int PIX_W   = 5,
  parameter int SPR_W   = 24,
  parameter int SPR_H   = 45,
  parameter int ROM_LAT = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  sprite_rom_arbiter_if.slave   bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            oob;
  } tag_t;

  logic [NUM_REQ-1:0][ADDR_W-1:0] laneAddr;
  logic [NUM_REQ-1:0]             laneOob;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : gLane
      sprite_rom_arbiter_lane #(
        .ADDR_W (ADDR_W),
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H)
      ) uLane (
        .base (bus.req_base[g]),
        .x    (bus.req_x[g]),
        .y    (bus.req_y[g]),
        .addr (laneAddr[g]),
        .oob  (laneOob[g])
      );
    end
  endgenerate

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gntId;
  logic [ID_W-1:0]    nextPtr;
  logic               gntAny;
  logic [NUM_REQ-1:0] gntVec;

  // Scan upward from ptr with wrap; first requester found wins.
  always_comb begin
    int idx;
    idx    = 0;
    gntAny = 1'b0;
    gntId  = '0;
    gntVec = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gntAny && bus.req[ID_W'(idx)]) begin
        gntAny = 1'b1;
        gntId  = ID_W'(idx);
      end
    end
    if (gntAny) gntVec[gntId] = 1'b1;
  end

  assign nextPtr = (int'(gntId) == NUM_REQ - 1) ? '0 : gntId + 1'b1;
  assign bus.gnt = gntVec;

  logic [ROM_LAT:0] vldPipe;
  tag_t [ROM_LAT:0] tagPipe;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr           <= '0;
      bus.rom_rd    <= 1'b0;
      bus.rom_addr  <= '0;
      vldPipe       <= '0;
      tagPipe       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_pixel <= '0;
    end else begin
      if (bus.frame_start)  ptr <= '0;
      else if (gntAny)      ptr <= nextPtr;

      // Out-of-bounds grants still take a pipeline slot but never touch the ROM.
      bus.rom_rd <= gntAny && !laneOob[gntId];
      if (gntAny) bus.rom_addr <= laneAddr[gntId];

      vldPipe[0]    <= gntAny;
      tagPipe[0].id  <= gntId;
      tagPipe[0].oob <= laneOob[gntId];
      for (int i = 1; i <= ROM_LAT; i++) begin
        vldPipe[i] <= vldPipe[i-1];
        tagPipe[i] <= tagPipe[i-1];
      end

      // Stage ROM_LAT lines up with rom_data; pixel holds between responses.
      bus.rsp_valid <= vldPipe[ROM_LAT];
      if (vldPipe[ROM_LAT]) begin
        bus.rsp_id    <= tagPipe[ROM_LAT].id;
        bus.rsp_pixel <= tagPipe[ROM_LAT].oob ? '0 : bus.rom_data;
      end
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: per-cycle model check plus directed literal pins.
module tb_sprite_rom_arbiter;
  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int PW  = 5;
  localparam int LAT = 1;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .PIX_W(PW)) bus();

  sprite_rom_arbiter #(
    .NUM_REQ (N), .ADDR_W (AW), .PIX_W (PW),
    .SPR_W   (24), .SPR_H (45), .ROM_LAT (LAT)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // ROM contents: never zero, so a zero pixel always means out-of-bounds.
  function automatic logic [PW-1:0] pix(input logic [AW-1:0] a);
    return PW'((int'(a) % 31) + 1);
  endfunction

  logic [PW-1:0] romQ [LAT];
  always @(posedge Clk) begin
    romQ[0] <= pix(bus.rom_addr);
    for (int i = 1; i < LAT; i++) romQ[i] <= romQ[i-1];
  end
  assign bus.rom_data = romQ[LAT-1];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: expected events scheduled by absolute cycle in a small ring.
  int mPtr = 0;
  int lastPix = 0;
  bit eRd [16];
  int eAddr [16];
  bit eV [16];
  int eId [16];
  int ePix [16];

  always @(negedge Clk) begin
    int s, k, adr;
    bit oob;
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin eRd[i] = 0; eV[i] = 0; end
      mPtr = 0;
      lastPix = 0;
      chk("rst_rom_rd",    bus.rom_rd,    0);
      chk("rst_rom_addr",  bus.rom_addr,  0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id",    bus.rsp_id,    0);
      chk("rst_rsp_pixel", bus.rsp_pixel, 0);
    end else begin
      s = cyc % 16;
      k = -1;
      for (int o = 0; o < N; o++)
        if (k < 0 && bus.req[(mPtr + o) % N]) k = (mPtr + o) % N;
      chk("gnt", bus.gnt, (k < 0) ? 0 : (1 << k));
      chk("rom_rd", bus.rom_rd, eRd[s]);
      if (eRd[s]) chk("rom_addr", bus.rom_addr, eAddr[s]);
      chk("rsp_valid", bus.rsp_valid, eV[s]);
      if (eV[s]) begin
        chk("rsp_id", bus.rsp_id, eId[s]);
        lastPix = ePix[s];
      end
      chk("rsp_pixel", bus.rsp_pixel, lastPix);
      eRd[s] = 0;
      eV[s]  = 0;
      if (k >= 0) begin
        oob = (int'(bus.req_x[k]) >= 24) || (int'(bus.req_y[k]) >= 45);
        adr = (int'(bus.req_base[k]) + int'(bus.req_y[k]) * 24 + int'(bus.req_x[k])) % 65536;
        eRd[(cyc + 1) % 16]         = !oob;
        eAddr[(cyc + 1) % 16]       = adr;
        eV[(cyc + 2 + LAT) % 16]    = 1;
        eId[(cyc + 2 + LAT) % 16]   = k;
        ePix[(cyc + 2 + LAT) % 16]  = oob ? 0 : int'(pix(AW'(adr)));
      end
      mPtr = bus.frame_start ? 0 : ((k >= 0) ? (k + 1) % N : mPtr);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic setOps(input int i, input int base, input int x, input int y);
    bus.req_base[i] = AW'(base);
    bus.req_x[i]    = 5'(x);
    bus.req_y[i]    = 6'(y);
  endtask

  initial begin
    bus.req = '0;
    bus.frame_start = 1'b0;
    for (int i = 0; i < N; i++) setOps(i, 0, 0, 0);
    #2 Reset_n = 1'b0;
    repeat (2) step();
    Reset_n = 1'b1;
    step();

    // 1: single in-bounds read, addr 2*24+3
    setOps(0, 0, 3, 2);
    bus.req = 4'b0001;
    @(negedge Clk); chk("t1_gnt", bus.gnt, 1);
    step(); bus.req = '0;
    @(negedge Clk); chk("t1_addr", bus.rom_addr, 51); chk("t1_rd", bus.rom_rd, 1);
    step(); step();
    @(negedge Clk);
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_id", bus.rsp_id, 0);
    chk("t1_rsp_pixel", bus.rsp_pixel, 21);
    step();

    // 2: all requesting from ptr=0 -> strict rotation
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    for (int i = 0; i < N; i++) setOps(i, i * 1000, i * 5, i * 10);
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk); chk("t2_gnt", bus.gnt, 1 << (i % 4));
      step();
    end
    bus.req = '0;
    repeat (4) step();

    // 3: out-of-bounds x
    setOps(1, 100, 24, 0);
    bus.req = 4'b0010;
    @(negedge Clk); chk("t3_gnt", bus.gnt, 2);
    step(); bus.req = '0;
    @(negedge Clk); chk("t3_rd", bus.rom_rd, 0);
    step(); step();
    @(negedge Clk);
    chk("t3_rsp_valid", bus.rsp_valid, 1);
    chk("t3_rsp_id", bus.rsp_id, 1);
    chk("t3_rsp_pixel", bus.rsp_pixel, 0);
    step();

    // 4: address wrap and last in-bounds pixel
    setOps(2, 16'hFFF0, 0, 1);
    bus.req = 4'b0100;
    @(negedge Clk); chk("t4_gnt_a", bus.gnt, 4);
    step();
    setOps(3, 0, 23, 44);
    bus.req = 4'b1000;
    @(negedge Clk); chk("t4_addr_wrap", bus.rom_addr, 8); chk("t4_gnt_b", bus.gnt, 8);
    step(); bus.req = '0;
    @(negedge Clk); chk("t4_addr_last", bus.rom_addr, 1079);
    repeat (4) step();

    // 5: frame_start while granting from ptr=2
    setOps(1, 200, 1, 1);
    bus.req = 4'b0010;
    step();
    setOps(3, 300, 2, 2);
    bus.req = 4'b1010;
    bus.frame_start = 1'b1;
    @(negedge Clk); chk("t5_gnt_fs", bus.gnt, 8);
    step();
    bus.frame_start = 1'b0;
    bus.req = 4'b0010;
    @(negedge Clk); chk("t5_gnt_after", bus.gnt, 2);
    step(); bus.req = '0;
    repeat (4) step();

    // 6: reset with two reads in flight
    setOps(0, 10, 1, 1);
    bus.req = 4'b0001;
    step();
    bus.req = 4'b0010;
    step();
    bus.req = '0;
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("t6_rd", bus.rom_rd, 0);
    chk("t6_addr", bus.rom_addr, 0);
    chk("t6_valid", bus.rsp_valid, 0);
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk); chk("t6_no_rsp", bus.rsp_valid, 0);
      step();
    end

    // Recovery: a fresh grant after reset still completes.
    setOps(2, 500, 4, 3);
    bus.req = 4'b0100;
    step(); bus.req = '0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
